// File: rtl/UART_MIKE_pkg.sv
// Shared types for the UART receive path: parity modes, the received-frame
// record and the default widest data field.
package UART_MIKE_pkg;

    localparam int unsigned DATA_W_MAX_DFLT = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_mode_e;

    typedef struct packed {
        logic [DATA_W_MAX_DFLT-1:0] data;
        logic                       parity_err;
        logic                       frame_err;
        logic                       brk;
    } rx_frame_t;

    localparam int unsigned RX_FRAME_W = $bits(rx_frame_t);

    function automatic logic [3:0] clamp_width(
        input logic [3:0] w,
        input logic [3:0] wmax
    );
        logic [3:0] r;
        r = w;
        if (w < 4'd5) begin
            r = 4'd5;
        end else if (w > wmax) begin
            r = wmax;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_frame_fifo.sv
// Small synchronous FIFO holding completed receive frames; head is presented
// combinationally with a valid/ready handshake and reads zero while empty.
module rx_frame_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop;
    logic             push_ok;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign out_valid_o = !empty_o;
    assign out_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign pop     = out_valid_o && out_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// UART receive frame assembler: bit sequencer plus frame FIFO.
// Optional break detection is enabled by defining RX_BREAK_DETECT_EN.
module rx_frame_assembler
    import UART_MIKE_pkg::*;
#(
    parameter int unsigned DATA_W_MAX = DATA_W_MAX_DFLT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       rx_shift,
    input  logic       rx,
    input  logic [3:0] cfg_data_width,
    input  logic [1:0] cfg_parity,
    input  logic       cfg_stop2,
    input  logic       out_ready,
    input  logic       overrun_clr,
    output logic       out_valid,
    output rx_frame_t  out_frame,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP1  = 3'd3;
    localparam logic [2:0] S_STOP2  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [3:0]            width_q, width_d;
    parity_mode_e          par_q, par_d;
    logic                  stop2_q, stop2_d;
    logic [DATA_W_MAX-1:0] data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  brk_d;
    logic                  push;
    rx_frame_t             push_frame;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RX_FRAME_W-1:0] fifo_data;
    logic                  overrun_q;

`ifdef RX_BREAK_DETECT_EN
    logic zero_q, zero_d;
    logic brk_q, brk_q_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        width_d   = width_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        brk_d     = 1'b0;
        push      = 1'b0;
`ifdef RX_BREAK_DETECT_EN
        zero_d    = zero_q;
        brk_q_d   = brk_q;
        brk_d     = brk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    width_d   = clamp_width(cfg_data_width, 4'(DATA_W_MAX));
                    par_d     = (cfg_parity == PAR_RSVD) ? PAR_NONE
                                                         : parity_mode_e'(cfg_parity);
                    stop2_d   = cfg_stop2;
                    data_d    = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
`ifdef RX_BREAK_DETECT_EN
                    zero_d    = 1'b1;
                    brk_q_d   = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (rx_shift) begin
                    for (int i = 0; i < int'(DATA_W_MAX); i++) begin
                        if (bit_cnt_q == 4'(i)) begin
                            data_d[i] = rx;
                        end
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef RX_BREAK_DETECT_EN
                    zero_d    = zero_q & ~rx;
`endif
                    if (bit_cnt_q == width_q - 4'd1) begin
                        state_d = (par_q != PAR_NONE) ? S_PARITY : S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_shift) begin
                    perr_d  = (par_q == PAR_EVEN) ? (^data_q ^ rx)
                                                  : ~(^data_q ^ rx);
`ifdef RX_BREAK_DETECT_EN
                    zero_d  = zero_q & ~rx;
`endif
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (rx_shift) begin
                    ferr_d = ferr_q | ~rx;
`ifdef RX_BREAK_DETECT_EN
                    brk_q_d = zero_q & ~rx;
                    brk_d   = brk_q_d;
`endif
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                if (rx_shift) begin
                    ferr_d  = ferr_q | ~rx;
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        push_frame                      = '0;
        push_frame.data[DATA_W_MAX-1:0] = data_d;
        push_frame.parity_err           = perr_d;
        push_frame.frame_err            = ferr_d | brk_d;
        push_frame.brk                  = brk_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            width_q   <= 4'd5;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            width_q   <= width_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

`ifdef RX_BREAK_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            brk_q  <= brk_q_d;
        end
    end
`endif

    rx_frame_fifo #(
        .WIDTH (RX_FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_frame),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_frame = rx_frame_t'(fifo_data);

    // Set wins over clear so a drop coinciding with a clear is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (push && fifo_full && !(out_valid && out_ready)) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Scoreboard bench for rx_frame_assembler: frames are modelled as they are
// driven and compared in order as the FIFO hands them out.
module tb_rx_frame_assembler;
    import UART_MIKE_pkg::*;

`ifdef RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       rx_shift = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] cfg_data_width = 4'd8;
    logic [1:0] cfg_parity = 2'd0;
    logic       cfg_stop2 = 1'b0;
    logic       out_ready = 1'b1;
    logic       overrun_clr = 1'b0;
    logic       out_valid;
    rx_frame_t  out_frame;
    logic       overrun;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    rx_frame_t exp_q[$];

    always #5 clk = ~clk;

    rx_frame_assembler #(
        .DATA_W_MAX (9),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .rx_shift       (rx_shift),
        .rx             (rx),
        .cfg_data_width (cfg_data_width),
        .cfg_parity     (cfg_parity),
        .cfg_stop2      (cfg_stop2),
        .out_ready      (out_ready),
        .overrun_clr    (overrun_clr),
        .out_valid      (out_valid),
        .out_frame      (out_frame),
        .overrun        (overrun),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        rx_frame_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'(out_frame), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("frame", 32'(out_frame), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_bit(input logic b);
        step();
        rx          = b;
        rx_shift    = 1'b1;
        frame_start = ($urandom_range(0, 3) == 0);
        step();
        rx_shift    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [8:0] d, input logic [3:0] w,
                              input logic [1:0] pm, input logic pbit,
                              input logic s1, input logic s2, input logic st2,
                              input bit do_exp, input bit chk_lat);
        int        weff;
        logic [8:0] dm;
        logic      has_par;
        logic      zero;
        rx_frame_t e;
        weff    = (w < 5) ? 5 : (w > 9) ? 9 : int'(w);
        dm      = d & 9'((1 << weff) - 1);
        has_par = (pm == 2'd1) || (pm == 2'd2);
        zero    = (dm == 9'd0) && !(has_par && pbit) && !s1;
        e            = '0;
        e.data       = dm;
        e.parity_err = (pm == 2'd1) ? (^dm ^ pbit) :
                       (pm == 2'd2) ? ~(^dm ^ pbit) : 1'b0;
        e.brk        = BRK_EN && zero;
        e.frame_err  = !s1 || (st2 && !s2) || e.brk;
        cfg_data_width = w;
        cfg_parity     = pm;
        cfg_stop2      = st2;
        frame_start    = 1'b1;
        rx_shift       = 1'b1;
        rx             = ~d[0];
        step();
        frame_start    = 1'b0;
        rx_shift       = 1'b0;
        cfg_data_width = w + 4'd3;
        cfg_parity     = pm ^ 2'b11;
        cfg_stop2      = ~st2;
        check("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < weff; i++) begin
            pulse_bit(d[i]);
        end
        if (has_par) begin
            pulse_bit(pbit);
        end
        pulse_bit(s1);
        if (st2) begin
            pulse_bit(s2);
        end
        if (do_exp) begin
            exp_q.push_back(e);
        end
        if (chk_lat) begin
            check("latency_valid", 32'(out_valid), 32'd1);
        end
        check("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            step();
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rx_frame_t head;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame", 32'(out_frame), 32'd0);

        // rx_shift in IDLE without frame_start must not start anything
        rx_shift = 1'b1;
        step();
        rx_shift = 1'b0;
        check("idle_shift", 32'(busy), 32'd0);

        send_frame(9'h0A5, 4'd8, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1);
        wait_drain();
        send_frame(9'h041, 4'd7, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0);
        send_frame(9'h041, 4'd7, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
        send_frame(9'h1FF, 4'd9, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0);
        send_frame(9'h1F3, 4'd3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
        send_frame(9'h155, 4'd15, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
        send_frame(9'h1AB, 4'd6, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0);
        for (int k = 0; k < 6; k++) begin
            send_frame(9'($urandom), 4'($urandom_range(5, 9)),
                       2'($urandom_range(0, 3)), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
        end
        wait_drain();

        out_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            send_frame(9'(8'h10 + 8'(k * 3)), 4'd8, 2'd0, 1'b0, 1'b1,
                       1'b1, 1'b0, (k < DEPTH), 0);
        end
        head = exp_q[0];
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_head", 32'(out_frame), 32'(head));
        repeat (3) step();
        check("ovr_hold", 32'(out_frame), 32'(head));
        out_ready = 1'b1;
        wait_drain();
        check("ovr_sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        cfg_data_width = 4'd8;
        cfg_parity     = 2'd0;
        cfg_stop2      = 1'b0;
        frame_start    = 1'b1;
        step();
        frame_start    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_bit(1'b1);
        end
        rst = 1'b1;
        step();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        send_frame(9'h03C, 4'd8, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1);
        wait_drain();

        send_frame(9'h000, 4'd8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
